// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer encodings, responder FSM states and
// the little-endian byte-lane decode used by SRAM-backed subordinates.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } resp_state_t;

  // Lanes touched by an aligned transfer of the given size at the given byte offset.
  function automatic logic [7:0] byte_lane_mask(input logic [2:0] size,
                                                input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0f;
      default:    base = 8'hff;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/ahbl_excl_monitor.sv
// Single-reservation exclusive-access monitor: tracks one word index and
// reports whether the completing exclusive transfer succeeded.
module ahbl_excl_monitor #(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_done,
  input  logic             i_ok,
  input  logic             i_excl,
  input  logic             i_write,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_success,
  output logic             o_resv_valid,
  output logic [IDX_W-1:0] o_resv_idx
);

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             w_event;
  logic             w_match;

  assign w_event      = i_done && i_ok;
  assign w_match      = r_valid && (r_idx == i_idx);
  assign o_success    = w_event && i_excl && (!i_write || w_match);
  assign o_resv_valid = r_valid;
  assign o_resv_idx   = r_idx;

  // Only OKAY completions touch the reservation; ERROR completions leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (w_event) begin
      if (i_excl && !i_write) begin
        r_valid <= 1'b1;
        r_idx   <= i_idx;
      end else if (i_excl && i_write) begin
        r_valid <= 1'b0;
      end else if (i_write && w_match) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite subordinate backed by a word-addressed SRAM, with programmable
// wait states, injected two-phase ERROR responses and an exclusive monitor.
module ahbl_sram_responder
  import ahbl_pkg::*;
#(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  output logic              ahbls_hexokay,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic              ahbls_hexcl,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic [3:0]        cfg_wait,
  input  logic              cfg_err
);

  localparam int unsigned NBYTES   = W_DATA / 8;
  localparam int unsigned OFF_W    = $clog2(NBYTES);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE = (W_DATA == 64) ? HSIZE_DWORD : HSIZE_WORD;

  resp_state_t       r_state;
  resp_state_t       w_state_nxt;

  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  r_off;
  logic [2:0]        r_size;
  logic              r_write;
  logic              r_excl;
  logic              r_err;
  logic              r_active;
  logic [3:0]        r_cnt;

  logic [W_DATA-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic [2:0]        w_align_mask;
  logic              w_misalign;
  logic              w_oversize;
  logic              w_err_in;
  logic              w_done;
  logic              w_ok;
  logic              w_excl_ok;
  logic              w_commit;
  logic [7:0]        w_mask;
  logic              w_resv_valid;
  logic [IDX_W-1:0]  w_resv_idx;
  logic              w_unused;

  assign w_accept     = ahbls_hready &&
                        !(ahbls_htrans == HTRANS_IDLE || ahbls_htrans == HTRANS_BUSY);
  assign w_align_mask = 3'((4'd1 << ahbls_hsize) - 4'd1);
  assign w_misalign   = |(ahbls_haddr[2:0] & w_align_mask);
  assign w_oversize   = ahbls_hsize > MAX_SIZE;
  assign w_err_in     = cfg_err || w_misalign || w_oversize;

  // A captured transfer completes in IDLE (OKAY) or ERR2 (ERROR).
  assign w_done   = r_active && (r_state == ST_IDLE || r_state == ST_ERR2);
  assign w_ok     = (r_state == ST_IDLE);
  assign w_mask   = byte_lane_mask(r_size, 3'(r_off));
  assign w_commit = w_done && w_ok && r_write && (!r_excl || w_excl_ok);

  assign ahbls_hexokay = w_excl_ok;
  assign ahbls_hrdata  = (r_active && !r_write) ? r_mem[r_idx] : '0;

  always_comb begin
    w_state_nxt       = r_state;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        ahbls_hresp = (r_state == ST_ERR2);
        if (w_accept) begin
          if (cfg_wait != '0)  w_state_nxt = ST_WAIT;
          else if (w_err_in)   w_state_nxt = ST_ERR1;
          else                 w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ahbls_hready_resp = 1'b0;
        if (r_cnt == 4'd1) w_state_nxt = r_err ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
        w_state_nxt       = ST_ERR2;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_off    <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_excl   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx    <= ahbls_haddr[OFF_W+IDX_W-1:OFF_W];
        r_off    <= ahbls_haddr[OFF_W-1:0];
        r_size   <= ahbls_hsize;
        r_write  <= ahbls_hwrite;
        r_excl   <= ahbls_hexcl;
        r_err    <= w_err_in;
        r_active <= 1'b1;
        r_cnt    <= cfg_wait;
      end else begin
        if (w_done) r_active <= 1'b0;
        if (r_state == ST_WAIT) r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // SRAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (w_mask[b]) r_mem[r_idx][b*8 +: 8] <= ahbls_hwdata[b*8 +: 8];
      end
    end
  end

  ahbl_excl_monitor #(
    .IDX_W(IDX_W)
  ) u_excl_monitor (
    .clk          (clk),
    .rst          (rst),
    .i_done       (w_done),
    .i_ok         (w_ok),
    .i_excl       (r_excl),
    .i_write      (r_write),
    .i_idx        (r_idx),
    .o_success    (w_excl_ok),
    .o_resv_valid (w_resv_valid),
    .o_resv_idx   (w_resv_idx)
  );

  assign w_unused = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_haddr,
                      w_mask, w_resv_valid, w_resv_idx};

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Self-checking bench for ahbl_sram_responder: directed scenarios plus
// randomized transfers checked against a word-array / reservation model.
module tb_ahbl_sram_responder;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    bit          excl;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic        ahbls_hexokay;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [2:0]  ahbls_hburst;
  logic [3:0]  ahbls_hprot;
  logic        ahbls_hmastlock;
  logic        ahbls_hexcl;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [3:0]  cfg_wait;
  logic        cfg_err;

  always #5 clk = ~clk;

  // Single-responder bus: HREADY is this responder's HREADYOUT.
  assign ahbls_hready = ahbls_hready_resp;

  ahbl_sram_responder #(
    .W_ADDR(32),
    .W_DATA(32),
    .DEPTH (1024)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ahbls_hready     (ahbls_hready),
    .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp      (ahbls_hresp),
    .ahbls_hexokay    (ahbls_hexokay),
    .ahbls_haddr      (ahbls_haddr),
    .ahbls_hwrite     (ahbls_hwrite),
    .ahbls_htrans     (ahbls_htrans),
    .ahbls_hsize      (ahbls_hsize),
    .ahbls_hburst     (ahbls_hburst),
    .ahbls_hprot      (ahbls_hprot),
    .ahbls_hmastlock  (ahbls_hmastlock),
    .ahbls_hexcl      (ahbls_hexcl),
    .ahbls_hwdata     (ahbls_hwdata),
    .ahbls_hrdata     (ahbls_hrdata),
    .cfg_wait         (cfg_wait),
    .cfg_err          (cfg_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: word array plus one reservation.
  logic [31:0] m_mem [1024];
  bit          m_rv;
  logic [9:0]  m_ri;

  // Observations of the most recent non-pipelined transfer.
  int          o_cyc;
  logic [15:0] o_hr, o_hs;
  logic        o_exok;
  logic [31:0] o_rd;

  function automatic logic [9:0] idx_of(input logic [31:0] a);
    return a[11:2];
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data, input bit excl);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.data = data; t.excl = excl;
    return t;
  endfunction

  function automatic bit is_err(input xfer_t t, input bit ferr);
    logic [31:0] am;
    am = (32'd1 << t.size) - 32'd1;
    return ferr || (t.size > 3'd2) || ((t.addr & am) != 32'd0);
  endfunction

  function automatic void m_write(input xfer_t t);
    for (int b = 0; b < (1 << t.size); b++) begin
      int lane;
      lane = int'(t.addr[1:0]) + b;
      m_mem[idx_of(t.addr)][lane*8 +: 8] = t.data[lane*8 +: 8];
    end
  endfunction

  // Applies an OKAY completion to the model; returns the expected HEXOKAY.
  function automatic bit m_okay(input xfer_t t);
    logic [9:0] i;
    bit hit;
    i   = idx_of(t.addr);
    hit = m_rv && (m_ri == i);
    if (!t.wr) begin
      if (t.excl) begin m_rv = 1'b1; m_ri = i; return 1'b1; end
      return 1'b0;
    end
    if (t.excl) begin
      m_rv = 1'b0;
      if (hit) m_write(t);
      return hit;
    end
    if (hit) m_rv = 1'b0;
    m_write(t);
    return 1'b0;
  endfunction

  task automatic drive_addr(input xfer_t t);
    ahbls_haddr  = t.addr;
    ahbls_hwrite = t.wr;
    ahbls_htrans = 2'b10;
    ahbls_hsize  = t.size;
    ahbls_hexcl  = t.excl;
  endtask

  task automatic go_idle();
    ahbls_htrans = 2'b00;
    ahbls_hwrite = 1'b0;
    ahbls_hexcl  = 1'b0;
  endtask

  // One isolated transfer; records the per-cycle response of its data phase.
  task automatic xfer(input xfer_t t, input logic [3:0] nw, input bit ferr);
    @(negedge clk);
    drive_addr(t);
    cfg_wait = nw;
    cfg_err  = ferr;
    @(negedge clk);
    go_idle();
    ahbls_hwdata = t.data;
    cfg_wait = 4'd0;
    cfg_err  = 1'b0;
    o_cyc = 0; o_hr = '0; o_hs = '0; o_exok = 1'b0; o_rd = '0;
    for (int k = 0; k < 16; k++) begin
      o_hr[k] = ahbls_hready_resp;
      o_hs[k] = ahbls_hresp;
      if (ahbls_hready_resp === 1'b1) begin
        o_cyc  = k + 1;
        o_exok = ahbls_hexokay;
        o_rd   = ahbls_hrdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go_idle();
    ahbls_haddr = '0; ahbls_hsize = 3'd2; ahbls_hburst = '0; ahbls_hprot = '0;
    ahbls_hmastlock = 1'b0; ahbls_hwdata = '0; cfg_wait = '0; cfg_err = 1'b0;
    m_rv = 1'b0; m_ri = '0;
    repeat (2) @(negedge clk);
    checks++; if (ahbls_hready_resp !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", ahbls_hready_resp); end
    checks++; if (ahbls_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", ahbls_hresp); end
    checks++; if (ahbls_hexokay !== 1'b0) begin errors++; $display("FAIL reset_hexokay: got %b want 0", ahbls_hexokay); end
    checks++; if (ahbls_hrdata !== 32'd0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", ahbls_hrdata); end
    rst = 1'b0;
  endtask

  // Zero-wait pipelined traffic; also initialises the words used by later tests.
  task automatic test_back_to_back();
    xfer_t q[$];
    xfer_t t;
    logic [31:0] a, exp;
    logic [2:0] sz;
    cfg_wait = 4'd0;
    cfg_err  = 1'b0;
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b0));
    for (int i = 0; i < 64; i++)
      q.push_back(mk(1'b1, (32'(i) << 2) | ($urandom & 32'hFFFF_F000), 3'd2, $urandom, 1'b0));
    for (int i = 0; i < 40; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = ($urandom & 32'hFFFF_F0FF) & ~((32'd1 << sz) - 32'd1);
      q.push_back(mk(1'($urandom_range(0, 1)), a, sz, $urandom, 1'b0));
    end
    @(negedge clk);
    drive_addr(q[0]);
    for (int k = 1; k <= q.size(); k++) begin
      @(negedge clk);
      t = q[k-1];
      checks++; if (ahbls_hready_resp !== 1'b1) begin errors++; $display("FAIL b2b_hready[%0d]: got %b want 1", k, ahbls_hready_resp); end
      if (!t.wr) begin
        exp = m_mem[idx_of(t.addr)];
        checks++; if (ahbls_hrdata !== exp) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, ahbls_hrdata, exp); end
      end
      void'(m_okay(t));
      ahbls_hwdata = t.data;
      if (k < q.size()) drive_addr(q[k]);
      else go_idle();
    end
    @(negedge clk);
  endtask

  task automatic test_wait_byte();
    xfer_t t;
    t = mk(1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0); xfer(t, 4'd0, 1'b0); void'(m_okay(t));
    t = mk(1'b1, 32'h13, 3'd0, 32'hAB000000, 1'b0); xfer(t, 4'd3, 1'b0);
    checks++; if (o_cyc !== 4) begin errors++; $display("FAIL wait3_cycles: got %0d want 4", o_cyc); end
    checks++; if (o_hr[3:0] !== 4'b1000) begin errors++; $display("FAIL wait3_hready: got %b want 1000", o_hr[3:0]); end
    void'(m_okay(t));
    t = mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== 32'hAB223344) begin errors++; $display("FAIL byte_merge: got %h want ab223344", o_rd); end
  endtask

  task automatic test_err_wait();
    xfer_t t;
    t = mk(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1'b0); xfer(t, 4'd2, 1'b1);
    checks++; if (o_hr[3:0] !== 4'b1000 || o_cyc !== 4) begin errors++; $display("FAIL err_hready: got %b/%0d want 1000/4", o_hr[3:0], o_cyc); end
    checks++; if (o_hs[3:0] !== 4'b1100) begin errors++; $display("FAIL err_hresp: got %b want 1100", o_hs[3:0]); end
    t = mk(1'b0, 32'h20, 3'd2, 32'h0, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== m_mem[8]) begin errors++; $display("FAIL err_nowrite: got %h want %h", o_rd, m_mem[8]); end
  endtask

  task automatic test_misaligned();
    xfer_t t;
    t = mk(1'b1, 32'h21, 3'd1, 32'h12345678, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_hr[1:0] !== 2'b10 || o_hs[1:0] !== 2'b11) begin errors++; $display("FAIL misalign_resp: got %b/%b want 10/11", o_hr[1:0], o_hs[1:0]); end
    t = mk(1'b0, 32'h20, 3'd2, 32'h0, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== m_mem[8]) begin errors++; $display("FAIL misalign_nowrite: got %h want %h", o_rd, m_mem[8]); end
  endtask

  task automatic test_excl();
    xfer_t t;
    t = mk(1'b0, 32'h40, 3'd2, 32'h0, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b1) begin errors++; $display("FAIL exrd_okay: got %b want 1", o_exok); end
    void'(m_okay(t));
    t = mk(1'b1, 32'h40, 3'd2, 32'h5, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b1) begin errors++; $display("FAIL exwr_okay: got %b want 1", o_exok); end
    void'(m_okay(t));
    t = mk(1'b1, 32'h40, 3'd2, 32'h9, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b0 || o_hs !== 16'd0 || o_cyc !== 1) begin errors++; $display("FAIL exwr_repeat: got exok=%b hresp=%h cyc=%0d want 0/0/1", o_exok, o_hs, o_cyc); end
    void'(m_okay(t));
    t = mk(1'b0, 32'h40, 3'd2, 32'h0, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== 32'h5) begin errors++; $display("FAIL exwr_suppressed: got %h want 5", o_rd); end
  endtask

  task automatic test_excl_clear();
    xfer_t t;
    t = mk(1'b0, 32'h40, 3'd2, 32'h0, 1'b1);  xfer(t, 4'd0, 1'b0); void'(m_okay(t));
    t = mk(1'b1, 32'h40, 3'd2, 32'h77, 1'b0); xfer(t, 4'd0, 1'b0); void'(m_okay(t));
    t = mk(1'b1, 32'h40, 3'd2, 32'h88, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b0) begin errors++; $display("FAIL exwr_after_plain: got %b want 0", o_exok); end
    void'(m_okay(t));
    t = mk(1'b0, 32'h40, 3'd2, 32'h0, 1'b0);  xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== 32'h77) begin errors++; $display("FAIL plain_kept: got %h want 77", o_rd); end
    t = mk(1'b0, 32'h44, 3'd2, 32'h0, 1'b1);  xfer(t, 4'd0, 1'b0); void'(m_okay(t));
    t = mk(1'b1, 32'h44, 3'd2, 32'h55, 1'b0); xfer(t, 4'd1, 1'b1);
    checks++; if (o_cyc !== 3 || o_exok !== 1'b0) begin errors++; $display("FAIL err_write_resp: got cyc=%0d exok=%b want 3/0", o_cyc, o_exok); end
    t = mk(1'b1, 32'h44, 3'd2, 32'h99, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b1) begin errors++; $display("FAIL resv_survives_err: got %b want 1", o_exok); end
    void'(m_okay(t));
    t = mk(1'b0, 32'h44, 3'd2, 32'h0, 1'b0);  xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== 32'h99) begin errors++; $display("FAIL resv_write_data: got %h want 99", o_rd); end
  endtask

  task automatic test_random();
    xfer_t t;
    logic [3:0] nw;
    bit ferr, e, exp_ex;
    int exp_cyc;
    logic [15:0] exp_hr, exp_hs;
    logic [31:0] exp_rd;
    for (int i = 0; i < 80; i++) begin
      t    = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F0FF, 3'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 3) == 0);
      nw   = 4'($urandom_range(0, 4));
      ferr = ($urandom_range(0, 5) == 0);
      e    = is_err(t, ferr);
      exp_rd = m_mem[idx_of(t.addr)];
      xfer(t, nw, ferr);
      exp_ex  = e ? 1'b0 : m_okay(t);
      exp_cyc = e ? int'(nw) + 2 : int'(nw) + 1;
      exp_hr  = 16'd1 << (exp_cyc - 1);
      exp_hs  = e ? (16'd3 << nw) : 16'd0;
      checks++; if (o_hr !== exp_hr) begin errors++; $display("FAIL rnd_hready[%0d]: got %h want %h", i, o_hr, exp_hr); end
      checks++; if (o_hs !== exp_hs) begin errors++; $display("FAIL rnd_hresp[%0d]: got %h want %h", i, o_hs, exp_hs); end
      checks++; if (o_exok !== exp_ex) begin errors++; $display("FAIL rnd_hexokay[%0d]: got %b want %b", i, o_exok, exp_ex); end
      if (!t.wr && !e) begin
        checks++; if (o_rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o_rd, exp_rd); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    xfer_t t;
    t = mk(1'b0, 32'h48, 3'd2, 32'h0, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b1) begin errors++; $display("FAIL pre_reset_exrd: got %b want 1", o_exok); end
    void'(m_okay(t));
    @(negedge clk);
    drive_addr(mk(1'b0, 32'h48, 3'd2, 32'h0, 1'b0));
    cfg_wait = 4'd5;
    @(negedge clk);
    go_idle();
    cfg_wait = 4'd0;
    @(negedge clk);
    checks++; if (ahbls_hready_resp !== 1'b0) begin errors++; $display("FAIL in_wait: got %b want 0", ahbls_hready_resp); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0) begin errors++; $display("FAIL async_reset: got hready=%b hresp=%b want 1/0", ahbls_hready_resp, ahbls_hresp); end
    checks++; if (ahbls_hrdata !== 32'd0) begin errors++; $display("FAIL async_reset_rdata: got %h want 0", ahbls_hrdata); end
    @(negedge clk);
    rst  = 1'b0;
    m_rv = 1'b0;
    t = mk(1'b1, 32'h48, 3'd2, 32'h1234, 1'b1); xfer(t, 4'd0, 1'b0);
    checks++; if (o_exok !== 1'b0) begin errors++; $display("FAIL resv_cleared: got %b want 0", o_exok); end
    void'(m_okay(t));
    t = mk(1'b0, 32'h48, 3'd2, 32'h0, 1'b0); xfer(t, 4'd0, 1'b0);
    checks++; if (o_rd !== m_mem[18]) begin errors++; $display("FAIL resv_cleared_nowrite: got %h want %h", o_rd, m_mem[18]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_byte();
    test_err_wait();
    test_misaligned();
    test_excl();
    test_excl_clear();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahbl_sram_responder.md
Name: ahbl_sram_responder

Overview:
- AHB-Lite subordinate (responder) backed by a word-addressed SRAM array.
- Used as the far-end target in simulation and formal harnesses for AHB-Lite masters (processor core, debug bus), so master-side properties can be exercised against a legal responder.
- Supports programmable wait states, injected two-phase ERROR responses, and a single-reservation exclusive-access monitor (HEXCL/HEXOKAY).

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; must be 32 or 64.
- DEPTH, 1024, number of W_DATA-wide words; power of two. Upper address bits alias.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ahbls_hready  in  1  bus HREADY (end of previous data phase)
- ahbls_hready_resp  out  1  this responder's HREADYOUT
- ahbls_hresp  out  1  ERROR response
- ahbls_hexokay  out  1  exclusive success
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  transfer size
- ahbls_hburst  in  3  burst (ignored)
- ahbls_hprot  in  4  protection (ignored)
- ahbls_hmastlock  in  1  lock (ignored)
- ahbls_hexcl  in  1  exclusive request
- ahbls_hwdata  in  W_DATA  write data
- ahbls_hrdata  out  W_DATA  read data
- cfg_wait  in  4  wait states for the next accepted transfer
- cfg_err  in  1  force ERROR on the next accepted transfer

Behaviour:
- Reset (async, active-high, any time, including mid-transfer): hready_resp=1, hresp=0, hexokay=0, hrdata=0, FSM=IDLE, reservation cleared. SRAM contents are not reset.
- Accept: when hready && htrans[1], capture addr, write, size, excl, wait=cfg_wait and err=cfg_err.
  - err is also forced if the transfer is misaligned, or if 8<<hsize > W_DATA.
  - IDLE/BUSY transfers are not captured and produce a zero-wait OKAY.
- FSM states:
  - IDLE: hready_resp=1, hresp=0.
  - WAIT: hready_resp=0, hresp=0; counter decrements each cycle.
  - ERR1: hready_resp=0, hresp=1.
  - ERR2: hready_resp=1, hresp=1.
- Transitions:
  - On accept, go to WAIT if wait>0.
  - Otherwise go to ERR1 if err; otherwise stay in IDLE (the completion cycle).
  - WAIT reaching counter 1 goes to ERR1 if err, else IDLE.
  - ERR1 always goes to ERR2.
  - ERR2 accepts the next transfer like IDLE.
- Latency:
  - OKAY completes N+1 cycles after the address phase (N=cfg_wait).
  - ERROR completes N+2 cycles after the address phase.
  - Back-to-back transfers are accepted in the completion cycle, giving zero-wait throughput of 1 transfer per cycle.
- Indexing: word index = addr[log2(DEPTH)+log2(W_DATA/8)-1 : log2(W_DATA/8)].
- Byte lanes: decoded from size and addr low bits (little-endian).
- Write: hwdata lanes are committed on the rising edge ending an OKAY completion cycle. No commit on ERROR.
- Read: hrdata = full SRAM word at the captured index while a read data phase is active, else 0. A read immediately following a write to the same word returns the new data.
- Exclusive monitor (one reservation: valid bit + word index):
  - Exclusive read OKAY: sets reservation to the index; hexokay=1 in the completion cycle.
  - Exclusive write OKAY, reservation valid and index match: commit, hexokay=1, clear reservation.
  - Exclusive write OKAY, no valid matching reservation: suppress write, hexokay=0, hresp=0, reservation cleared.
  - Non-exclusive write OKAY to the reserved index: clears the reservation.
  - ERROR transfers never alter the reservation.
- hexokay is high only in the completion cycle of a successful exclusive OKAY transfer.
- Address-phase inputs are ignored while hready=0. A master changing htrans to IDLE during ERR1 is legal and has no effect.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ and HSIZE_BYTE/HALF/WORD/DWORD constants.
  - Responder FSM state encoding (2 bits).
  - Byte-lane mask function.
- One sub-module, ahbl_excl_monitor:
  - Inputs: completion strobe, excl, write, index, ok.
  - Outputs: success, reservation state.

Test Plan:
- cfg_wait=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> hready_resp=1 every cycle; hrdata=0xDEADBEEF in the read data phase.
- cfg_wait=3, byte write 0xAB @0x13 over word 0x11223344 -> hready_resp low 3 cycles then high; word reads 0xAB223344.
- cfg_err=1, cfg_wait=2, write @0x20 -> hready_resp 0,0,0,1 with hresp 0,0,1,1; word @0x20 unchanged.
- Halfword access @0x21 with cfg_err=0 -> forced ERROR (ERR1, ERR2); no memory change.
- Exclusive read @0x40, then exclusive write 0x5 @0x40 -> hexokay=1 on both; data written. Repeat the exclusive write -> hexokay=0 and no write.
- Exclusive read @0x40, plain write @0x40, then exclusive write -> hexokay=0. Assert rst during WAIT -> hready_resp=1 and hresp=0 immediately; reservation cleared.
